// File: rtl/multiplicador_sat_param.sv
// Sequential shift-and-add WIDTH x WIDTH multiplier with result saturated to WIDTH bits.
// Latency WIDTH+1 edges from the START edge to Pronto; START is ignored while Ocupado is high.
// MULT_SAT_SIGNED_EN selects two's-complement operands and signed saturation.
module multiplicador_sat_param #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Resultado,
    output logic             Overflow,
    output logic             Pronto,
    output logic             Ocupado
);
    localparam int CONT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   accept;
    logic                   last_iter;
    logic [WIDTH-1:0]       mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [CONT_W-1:0]      cnt_q;
    logic [WIDTH-1:0]       sat_res;
    logic                   sat_ovf;
`ifdef MULT_SAT_SIGNED_EN
    logic                   neg_q;
`endif

    assign last_iter = (cnt_q == CONT_W'(WIDTH));
    assign Ocupado   = (state == CALC);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC:    if (last_iter) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MULT_SAT_SIGNED_EN
    // Accumulator holds |A|*|B|; the sign is reapplied only when loading the outputs.
    logic [WIDTH-1:0] pos_max, neg_min;
    assign pos_max = {1'b0, {(WIDTH-1){1'b1}}};
    assign neg_min = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        sat_res = acc_q[WIDTH-1:0];
        sat_ovf = 1'b0;
        if (neg_q && (acc_q != '0)) begin
            if (acc_q > {{WIDTH{1'b0}}, neg_min}) begin
                sat_res = neg_min;
                sat_ovf = 1'b1;
            end else begin
                sat_res = -acc_q[WIDTH-1:0];
            end
        end else if (acc_q > {{WIDTH{1'b0}}, pos_max}) begin
            sat_res = pos_max;
            sat_ovf = 1'b1;
        end
    end
`else
    always_comb begin
        sat_res = acc_q[WIDTH-1:0];
        sat_ovf = 1'b0;
        if (acc_q[2*WIDTH-1:WIDTH] != '0) begin
            sat_res = '1;
            sat_ovf = 1'b1;
        end
    end
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            Resultado <= '0;
            Overflow  <= 1'b0;
            Pronto    <= 1'b0;
`ifdef MULT_SAT_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else if (accept) begin
`ifdef MULT_SAT_SIGNED_EN
            mcand_q   <= A[WIDTH-1] ? -A : A;
            mplier_q  <= B[WIDTH-1] ? -B : B;
            neg_q     <= A[WIDTH-1] ^ B[WIDTH-1];
`else
            mcand_q   <= A;
            mplier_q  <= B;
`endif
            acc_q     <= '0;
            cnt_q     <= '0;
            Resultado <= '0;
            Overflow  <= 1'b0;
            Pronto    <= 1'b0;
        end else if (state == CALC) begin
            if (last_iter) begin
                Resultado <= sat_res;
                Overflow  <= sat_ovf;
                Pronto    <= 1'b1;
            end else begin
                // Full 2*WIDTH add: the partial sum never exceeds the final product.
                if (mplier_q[0])
                    acc_q <= acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CONT_W'(1);
            end
        end
    end
endmodule
